alu_result_fifo: RTL and testbench

//  Downstream stage of the arithmetic unit. It captures each signed 6-bit result together with
//  the 3-bit op select that produced it, then derives status flags (zero, negative, outside the
//  4-bit range). Results are buffered in a small FIFO with valid/ready handshakes on both sides,
//  so the consumer (display or register file) can stall without losing results.
//  A sticky range-error flag records any result that did not fit in 4 signed bits.

---
 rtl/alu_result_fifo.sv | 112 +++++++++++
 tb/tb_alu_result_fifo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// Result buffer behind the arithmetic unit: stores signed results with their op select,
// flags the head entry and keeps a sticky record of any out-of-range result accepted.
module alu_result_fifo #(
  parameter int RES_W = 6,
  parameter int SEL_W = 3,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_res,
  input  logic [SEL_W-1:0] in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_res,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_rng,
  output logic [CNT_W-1:0] count,
  output logic             rng_err,
  input  logic             clr_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // True when a signed RES_W value does not fit in 4 signed bits.
  function automatic logic out_of_range(input logic [RES_W-1:0] v);
    logic signed [RES_W-1:0] sv;
    sv = v;
    return (int'(sv) > 32'sd7) || (int'(sv) < -32'sd8);
  endfunction

  logic [RES_W-1:0] res_mem_r [DEPTH];
  logic [SEL_W-1:0] sel_mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             rng_err_r;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             push_s;
  logic             pop_s;

  // Handshake qualifiers depend only on the occupancy register, so out_ready never reaches in_ready.
  assign in_ready_s  = (count_r != CNT_W'(DEPTH));
  assign out_valid_s = (count_r != {CNT_W{1'b0}});
  assign push_s      = in_valid & in_ready_s;
  assign pop_s       = out_valid_s & out_ready;

  // Storage array: written on push, deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      res_mem_r[wr_ptr_r] <= in_res;
      sel_mem_r[wr_ptr_r] <= in_sel;
    end
  end

  // Pointers, occupancy and sticky range error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      rng_err_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      // A failing push in the same cycle as clr_err keeps the error set.
      if (push_s && out_of_range(in_res)) begin
        rng_err_r <= 1'b1;
      end else if (clr_err) begin
        rng_err_r <= 1'b0;
      end
    end
  end

  // Head entry and its flags; everything reads as zero while empty.
  always_comb begin
    out_res  = {RES_W{1'b0}};
    out_sel  = {SEL_W{1'b0}};
    out_zero = 1'b0;
    out_neg  = 1'b0;
    out_rng  = 1'b0;
    if (out_valid_s) begin
      out_res  = res_mem_r[rd_ptr_r];
      out_sel  = sel_mem_r[rd_ptr_r];
      out_zero = ~|res_mem_r[rd_ptr_r];
      out_neg  = res_mem_r[rd_ptr_r][RES_W-1];
      out_rng  = out_of_range(res_mem_r[rd_ptr_r]);
    end else begin
      out_res  = {RES_W{1'b0}};
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign count     = count_r;
  assign rng_err   = rng_err_r;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: a driver pushes hand-computed expectations into a
// scoreboard queue and a negedge monitor compares every presented head entry against it.
module tb_alu_result_fifo;

  typedef struct packed {
    logic signed [5:0] res;
    logic [2:0]        sel;
    logic              z;
    logic              n;
    logic              r;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b1;
  logic       in_ready;
  logic [5:0] in_res = 6'd0;
  logic [2:0] in_sel = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] out_res;
  logic [2:0] out_sel;
  logic       out_zero, out_neg, out_rng;
  logic [2:0] count;
  logic       rng_err;
  logic       clr_err = 1'b0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t cur_exp;

  alu_result_fifo #(.RES_W(6), .SEL_W(3), .DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_res(in_res), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_sel(out_sel), .out_zero(out_zero), .out_neg(out_neg),
    .out_rng(out_rng), .count(count), .rng_err(rng_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic signed [5:0] res, input logic [2:0] sel,
                      input logic z, input logic n, input logic r);
    in_valid = 1'b1;
    in_res   = res;
    in_sel   = sel;
    cur_exp  = '{res: res, sel: sel, z: z, n: n, r: r};
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: compare head entry mid-cycle, retire it if a pop is about to happen, record pushes.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          check("out_res",  int'($signed(out_res)), int'(sb[0].res));
          check("out_sel",  int'(out_sel),  int'(sb[0].sel));
          check("out_zero", int'(out_zero), int'(sb[0].z));
          check("out_neg",  int'(out_neg),  int'(sb[0].n));
          check("out_rng",  int'(out_rng),  int'(sb[0].r));
          if (out_ready) void'(sb.pop_front());
        end
      end else begin
        check("empty_out_res", int'(out_res), 0);
        check("empty_out_sel", int'(out_sel), 0);
        check("empty_flags", int'({out_zero, out_neg, out_rng}), 0);
        check("empty_vs_sb", sb.size(), 0);
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset held two cycles with in_valid high
    step(); step();
    check("rst_count", int'(count), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_rng_err", int'(rng_err), 0);
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    check("idle_count", int'(count), 0);

    // 2: out-of-range result 14 from 7+7
    push(6'sd14, 3'b110, 1'b0, 1'b0, 1'b1);
    check("t2_count", int'(count), 1);
    check("t2_rng_err", int'(rng_err), 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("t2_drained", int'(count), 0);

    // 3: fill, hold a refused push, drain in order
    push(-6'sd8, 3'd1, 1'b0, 1'b1, 1'b0);
    push(6'sd0,  3'd2, 1'b1, 1'b0, 1'b0);
    push(6'sd5,  3'd3, 1'b0, 1'b0, 1'b0);
    push(-6'sd1, 3'd4, 1'b0, 1'b1, 1'b0);
    check("t3_full_count", int'(count), 4);
    check("t3_full_in_ready", int'(in_ready), 0);
    in_valid = 1'b1; in_res = 6'sd9; in_sel = 3'd5;
    cur_exp = '{res: 6'sd9, sel: 3'd5, z: 1'b0, n: 1'b0, r: 1'b1};
    step(); step();
    check("t3_hold_count", int'(count), 4);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
    check("t3_drained", int'(count), 0);
    check("t3_sb_empty", sb.size(), 0);

    // 4: simultaneous push/pop at count 2 across pointer wrap
    push(6'sd3,  3'd0, 1'b0, 1'b0, 1'b0);
    push(-6'sd5, 3'd1, 1'b0, 1'b1, 1'b0);
    out_ready = 1'b1;
    push(6'sd7,   3'd2, 1'b0, 1'b0, 1'b0); check("t4_count", int'(count), 2);
    push(-6'sd8,  3'd3, 1'b0, 1'b1, 1'b0); check("t4_count", int'(count), 2);
    push(6'sd20,  3'd4, 1'b0, 1'b0, 1'b1); check("t4_count", int'(count), 2);
    push(-6'sd20, 3'd5, 1'b0, 1'b1, 1'b1); check("t4_count", int'(count), 2);
    push(6'sd0,   3'd6, 1'b1, 1'b0, 1'b0); check("t4_count", int'(count), 2);
    push(-6'sd32, 3'd7, 1'b0, 1'b1, 1'b1); check("t4_count", int'(count), 2);
    step(); step();
    out_ready = 1'b0;
    check("t4_drained", int'(count), 0);

    // 5: pop and refused push on the same edge while full
    push(6'sd1,  3'd0, 1'b0, 1'b0, 1'b0);
    push(6'sd2,  3'd1, 1'b0, 1'b0, 1'b0);
    push(6'sd8,  3'd2, 1'b0, 1'b0, 1'b1);
    push(-6'sd9, 3'd3, 1'b0, 1'b1, 1'b1);
    check("t5_full", int'(count), 4);
    out_ready = 1'b1;
    push(6'sd31, 3'd4, 1'b0, 1'b0, 1'b1);
    out_ready = 1'b0;
    check("t5_count", int'(count), 3);
    check("t5_in_ready", int'(in_ready), 1);

    // 6: clear, set-wins-over-clear, clear again, reset mid-operation
    clr_err = 1'b1; step(); clr_err = 1'b0;
    check("t6_cleared", int'(rng_err), 0);
    clr_err = 1'b1;
    push(6'sd16, 3'd7, 1'b0, 1'b0, 1'b1);
    clr_err = 1'b0;
    check("t6_set_wins", int'(rng_err), 1);
    check("t6_count4", int'(count), 4);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    check("t6_clr_alone", int'(rng_err), 0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("t6_count3", int'(count), 3);
    rst = 1'b1; step(); rst = 1'b0;
    sb.delete();
    check("t6_rst_count", int'(count), 0);
    check("t6_rst_out_valid", int'(out_valid), 0);
    check("t6_rst_in_ready", int'(in_ready), 1);
    check("t6_rst_out_res", int'(out_res), 0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
